dma_fifo: RTL and testbench

Eight-entry, 32-bit-wide data FIFO between the CPU-bus DMA state machine and the SCSI byte port. The CPU side writes and reads whole longwords; the SCSI side writes and reads single bytes through a shared byte-lane pointer. The DMA state machine drives the pointer and counter strobes. The FIFO returns the status flags that the state machine branches on: FIFOEMPTY, FIFOFULL, LASTWORD and BOEQ3.

---
 rtl/dma_fifo.sv | 94 +++++++++
 tb/tb_dma_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo.sv
// Eight-longword DMA data FIFO between the CPU bus and the SCSI byte port.
// Longword and byte-lane access share one entry array; status flags decode from registered state.
module dma_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic [31:0]      ID,
    input  logic             LLWORD,
    input  logic             LHWORD,
    input  logic [7:0]       SD_IN,
    input  logic             BYTE_WR,
    input  logic             INCNI,
    input  logic             INCNO,
    input  logic             INCBO,
    input  logic             INCFIFO,
    input  logic             DECFIFO,
    output logic [31:0]      OD,
    output logic [7:0]       SD_OUT,
    output logic [1:0]       BO,
    output logic [PTR_W:0]   COUNT,
    output logic             FIFOEMPTY,
    output logic             FIFOFULL,
    output logic             LASTWORD,
    output logic             BOEQ3,
    output logic             OVERRUN
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] ni_q, no_q;
    logic [1:0]       bo_q;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic [31:0]      wdata;
    logic             we;

    // Merge all write sources into entry[NI]; the byte write lands last so it owns its lane.
    always_comb begin
        wdata = mem_q[ni_q];
        if (LHWORD)  wdata[31:16] = ID[31:16];
        if (LLWORD)  wdata[15:0]  = ID[15:0];
        if (BYTE_WR) wdata[{~bo_q, 3'b000} +: 8] = SD_IN;
        we = LLWORD | LHWORD | BYTE_WR;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (INCFIFO && !DECFIFO) begin
            if (cnt_q == FULL_CNT) ovr_d = 1'b1;
            else                   cnt_d = cnt_q + 1'b1;
        end else if (DECFIFO && !INCFIFO) begin
            if (cnt_q == '0)       ovr_d = 1'b1;
            else                   cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ni_q  <= '0;
            no_q  <= '0;
            bo_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else if (FLUSH) begin
            ni_q  <= '0;
            no_q  <= '0;
            bo_q  <= '0;
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (we)    mem_q[ni_q] <= wdata;
            if (INCNI) ni_q <= ni_q + 1'b1;
            if (INCNO) no_q <= no_q + 1'b1;
            if (INCBO) bo_q <= bo_q + 2'd1;
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    assign OD        = mem_q[no_q];
    assign SD_OUT    = OD[{~bo_q, 3'b000} +: 8];
    assign BO        = bo_q;
    assign COUNT     = cnt_q;
    assign FIFOEMPTY = (cnt_q == '0);
    assign FIFOFULL  = (cnt_q == FULL_CNT);
    assign LASTWORD  = (cnt_q == (PTR_W+1)'(1));
    assign BOEQ3     = (bo_q == 2'd3);
    assign OVERRUN   = ovr_q;
endmodule

// File: tb/tb_dma_fifo.sv
// Scoreboard bench for dma_fifo: directed scenarios plus random strobes against a queue-fed reference model.
module tb_dma_fifo;
    logic        CLK = 0, RESET = 0, FLUSH = 0;
    logic [31:0] ID = 0;
    logic        LLWORD = 0, LHWORD = 0, BYTE_WR = 0;
    logic [7:0]  SD_IN = 0;
    logic        INCNI = 0, INCNO = 0, INCBO = 0, INCFIFO = 0, DECFIFO = 0;
    logic [31:0] OD;
    logic [7:0]  SD_OUT;
    logic [1:0]  BO;
    logic [3:0]  COUNT;
    logic        FIFOEMPTY, FIFOFULL, LASTWORD, BOEQ3, OVERRUN;

    dma_fifo #(.DEPTH(8), .PTR_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .ID(ID), .LLWORD(LLWORD), .LHWORD(LHWORD),
        .SD_IN(SD_IN), .BYTE_WR(BYTE_WR), .INCNI(INCNI), .INCNO(INCNO), .INCBO(INCBO),
        .INCFIFO(INCFIFO), .DECFIFO(DECFIFO), .OD(OD), .SD_OUT(SD_OUT), .BO(BO), .COUNT(COUNT),
        .FIFOEMPTY(FIFOEMPTY), .FIFOFULL(FIFOFULL), .LASTWORD(LASTWORD), .BOEQ3(BOEQ3), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] od; logic [7:0] sd; logic [1:0] bo; logic [3:0] cnt;
        logic emp; logic full; logic last; logic b3; logic ovr;
    } exp_t;

    typedef struct {
        bit flush; bit [31:0] id; bit ll; bit lh; bit [7:0] sd; bit bw;
        bit incni; bit incno; bit incbo; bit incf; bit decf;
    } stim_t;

    // reference state: plain integers with modular wrap
    bit [31:0] m_mem [8];
    int m_ni, m_no, m_bo, m_cnt;
    bit m_ovr;

    exp_t exp_q [$];
    int vectors = 0, miscompares = 0;

    function automatic exp_t model_out();
        exp_t e;
        bit [31:0] w;
        w = m_mem[m_no];
        e.od = w;
        e.sd = w[8*(3-m_bo) +: 8];
        e.bo = 2'(m_bo);
        e.cnt = 4'(m_cnt);
        e.emp = (m_cnt == 0);
        e.full = (m_cnt == 8);
        e.last = (m_cnt == 1);
        e.b3 = (m_bo == 3);
        e.ovr = m_ovr;
        return e;
    endfunction

    function automatic exp_t dut_out();
        exp_t a;
        a = '{OD, SD_OUT, BO, COUNT, FIFOEMPTY, FIFOFULL, LASTWORD, BOEQ3, OVERRUN};
        return a;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 0;
        m_ni = 0; m_no = 0; m_bo = 0; m_cnt = 0; m_ovr = 0;
    endtask

    task automatic model_step(input stim_t s);
        bit [31:0] w;
        if (s.flush) begin
            m_ni = 0; m_no = 0; m_bo = 0; m_cnt = 0; m_ovr = 0;
            return;
        end
        w = m_mem[m_ni];
        if (s.lh) w[31:16] = s.id[31:16];
        if (s.ll) w[15:0] = s.id[15:0];
        if (s.bw) w[8*(3-m_bo) +: 8] = s.sd;
        m_mem[m_ni] = w;
        m_ni = (m_ni + int'(s.incni)) % 8;
        m_no = (m_no + int'(s.incno)) % 8;
        m_bo = (m_bo + int'(s.incbo)) % 4;
        if (s.incf && !s.decf) begin
            if (m_cnt == 8) m_ovr = 1; else m_cnt++;
        end else if (s.decf && !s.incf) begin
            if (m_cnt == 0) m_ovr = 1; else m_cnt--;
        end
    endtask

    task automatic compare(input string name, input exp_t a, input exp_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got od=%h sd=%h bo=%0d cnt=%0d emp=%b full=%b last=%b b3=%b ovr=%b, want od=%h sd=%h bo=%0d cnt=%0d emp=%b full=%b last=%b b3=%b ovr=%b",
                     name, a.od, a.sd, a.bo, a.cnt, a.emp, a.full, a.last, a.b3, a.ovr,
                     e.od, e.sd, e.bo, e.cnt, e.emp, e.full, e.last, e.b3, e.ovr);
        end
    endtask

    // monitor: one expectation is consumed after every edge that had stimulus behind it
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) compare("cycle", dut_out(), exp_q.pop_front());
        end
    end

    task automatic drive(input stim_t s);
        @(negedge CLK);
        FLUSH = s.flush; ID = s.id; LLWORD = s.ll; LHWORD = s.lh; SD_IN = s.sd; BYTE_WR = s.bw;
        INCNI = s.incni; INCNO = s.incno; INCBO = s.incbo; INCFIFO = s.incf; DECFIFO = s.decf;
        model_step(s);
        exp_q.push_back(model_out());
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    task automatic quiesce();
        drive(idle());
        @(posedge CLK);
        #3;
    endtask

    stim_t s;
    int    bound;

    initial begin
        model_reset();
        RESET = 1;
        #1 compare("reset_state", dut_out(), model_out());
        #10 RESET = 0;

        // CPU fill of 8 longwords, then a 9th count increment overruns
        for (int n = 0; n < 8; n++) begin
            s = idle(); s.id = 32'h11223344 + n; s.ll = 1; s.lh = 1; s.incni = 1; s.incf = 1;
            drive(s);
        end
        s = idle(); s.incf = 1; drive(s);
        s = idle(); s.flush = 1; drive(s);

        // SCSI byte read of a single longword
        s = idle(); s.id = 32'hA1B2C3D4; s.ll = 1; s.lh = 1; s.incni = 1; s.incf = 1; drive(s);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.incbo = 1; drive(s);
        end
        s = idle(); s.incbo = 1; s.incno = 1; s.decf = 1; drive(s);
        s = idle(); s.flush = 1; drive(s);

        // SCSI byte write assembling 0xDEADBEEF
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.bw = 1; s.incbo = 1;
            case (i)
                0: s.sd = 8'hDE;
                1: s.sd = 8'hAD;
                2: s.sd = 8'hBE;
                default: begin s.sd = 8'hEF; s.incni = 1; s.incf = 1; end
            endcase
            drive(s);
        end

        // pass-through across the pointer wrap with simultaneous inc/dec
        for (int i = 0; i < 20; i++) begin
            s = idle(); s.id = $urandom; s.ll = 1; s.lh = 1; s.incni = 1; s.incno = 1;
            s.incf = 1; s.decf = 1;
            drive(s);
        end
        s = idle(); s.flush = 1; drive(s);
        s = idle(); s.decf = 1; drive(s);
        s = idle(); s.flush = 1; drive(s);

        // asynchronous reset with COUNT=5 and BO=2
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.id = $urandom; s.ll = 1; s.lh = 1; s.incni = 1; s.incf = 1;
            s.incbo = (i < 2); drive(s);
        end
        quiesce();
        RESET = 1;
        model_reset();
        #1 compare("async_reset", dut_out(), model_out());
        @(posedge CLK);
        @(negedge CLK);
        RESET = 0;

        // random strobes
        for (int i = 0; i < 600; i++) begin
            s.flush = ($urandom_range(0, 40) == 0);
            s.id = $urandom; s.sd = 8'($urandom);
            s.ll = $urandom_range(0, 1); s.lh = $urandom_range(0, 1); s.bw = $urandom_range(0, 1);
            s.incni = $urandom_range(0, 1); s.incno = $urandom_range(0, 1);
            s.incbo = $urandom_range(0, 1);
            s.incf = $urandom_range(0, 1); s.decf = $urandom_range(0, 1);
            drive(s);
        end
        drive(idle());

        bound = 0;
        while (exp_q.size() > 0 && bound < 20) begin
            @(posedge CLK);
            bound++;
        end
        #3;
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
